util_axis_1553_encoder: RTL and testbench
=========================================

# util_axis_1553_encoder

AXI-Stream to MIL-STD-1553 Manchester II encoder. It accepts one 16-bit word per transfer and emits it as a 20-bit-time 1553 word on a differential output pair: a 3-bit-time sync, 16 data bits MSB first, and an odd parity bit. It sits between the bus-controller/RT logic (AXIS master) and the transceiver driver.

## Interface
- clock_speed, default 20000000: aclk frequency in Hz.
  - Must be a multiple of 2000000.
  - HALF = clock_speed/2000000 clocks per half-bit.
  - BIT = 2·HALF clocks per bit, giving 1 Mbit/s.
- aclk  input  1  sole clock; all logic on rising edge.
- arstn  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  16  word to transmit; bit 15 goes first.
- s_axis_tvalid  input  1  word available.
- s_axis_tuser  input  8  transfer control.
  - [7:5] sync select: 3'b100 selects command/status sync; any other value selects data sync.
  - [4:0] reserved, ignored.
- s_axis_tready  output  1  encoder idle and able to accept.
- diff  output  2  driver pair, registered.
  - [1] is the positive leg, [0] is the negative leg.
  - 2'b10 = high, 2'b01 = low, 2'b00 = idle/off.
  - 2'b11 is never driven.

## Operation
- States: IDLE, SYNC, DATA, PARITY.
- IDLE
  - s_axis_tready=1, diff=00.
  - On tvalid&tready: capture tdata and tuser[7:5], compute odd parity (parity bit = ~^tdata), and go to SYNC.
  - s_axis_tready drops to 0 on the same edge.
- SYNC: 3·HALF clocks each of two levels.
  - Command/status: high then low.
  - Data: low then high.
- DATA: 16 bits, MSB first, each bit two halves of HALF clocks.
  - Logic 1 = high then low.
  - Logic 0 = low then high.
- PARITY: one bit, encoded the same way as a data bit. Then return to IDLE.
- A single down-counter of HALF clocks and a half-bit index (0..39) sequence the word.
- The sync occupies half-bit indices 0..5 and is driven at the same level throughout each of its 3-half-bit segments.
- Input changes while busy are ignored; captured data is held internally.
- Reset, asserted at any time including mid-word:
  - State → IDLE, diff=00 immediately (asynchronously), s_axis_tready=0.
  - Counters and captured data cleared.
  - First rising edge after arstn deasserts sets s_axis_tready=1.
  - No partial word resumes.

## Timing
- Accept edge T (tvalid&tready sampled high). diff shows the first sync level from edge T+1.
- Word duration: 40·HALF clocks (400 at 20 MHz).
  - Sync: 6·HALF.
  - Data: 32·HALF.
  - Parity: 2·HALF.
- After the last parity half, diff=00 and s_axis_tready=1 for at least one clock (IDLE).
- Back-to-back words with tvalid held high: accept period is 40·HALF+1 clocks (401 at 20 MHz), with exactly one 00 cycle between words.
- Never more than one acceptance per word. tready is low from edge T until the word ends.
- diff level changes only on half-bit boundaries. Mid-bit transition at HALF clocks into each bit.

## Test plan
- Reset check: hold arstn low 2 cycles.
  - diff=00 and tready=0 during reset.
  - tready=1 one edge after release.
  - Assert arstn low mid-DATA → diff=00 at once, encoder back to IDLE.
- Command word: tdata=16'hFFFF, tuser=8'h8F, clock_speed=20e6.
  - diff=10 for 30 clocks, then 01 for 30.
  - Then 16×(10 for 10 clocks, 01 for 10).
  - Parity 1: 10 for 10, 01 for 10.
  - Then 00 with tready=1.
- Data word: tdata=16'h0000, tuser=8'h40.
  - diff=01 for 30, then 10 for 30.
  - 16×(01 for 10, 10 for 10).
  - Parity 1: 10 for 10, 01 for 10.
- Parity 0: tdata=16'h0001, tuser=8'h8F → parity half-bits are 01 then 10 (10 clocks each).
- Streaming: tvalid constantly high, tdata incremented on each accept starting at 16'hFFFF.
  - Accepts every 401 clocks.
  - Second word carries 16'h0000 with command sync.
  - Exactly one diff=00 cycle between words.
- Parameter check: clock_speed=4000000 (HALF=2), tdata=16'hA5A5, tuser=8'h8F → word lasts 80 clocks; bit transitions every 2 clocks; parity 1.

Source files
------------

// File: rtl/util_axis_1553_encoder.sv
// util_axis_1553_encoder: AXI-Stream word to MIL-STD-1553 Manchester II differential output.
module util_axis_1553_encoder #(
  parameter int clock_speed = 20000000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [1:0]  diff
);
  localparam int half = clock_speed / 2000000;
  localparam int cw = half > 1 ? $clog2(half) : 1;
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;
  state_t state;
  logic [cw-1:0] cnt;
  logic [5:0] idx;
  logic [16:0] sh;
  logic cmd, lvl, last, unused;
  always_comb unused = ^s_axis_tuser[4:0];
  always_comb last = cnt == '0;
  // sync flips level after three half-bits; Manchester bits invert on the odd half
  always_comb lvl = state == SYNC ? cmd ^ (idx >= 6'd3) : sh[16] ^ idx[0];
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state <= IDLE;
      s_axis_tready <= 1'b0;
      diff <= 2'b00;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      cmd <= 1'b0;
    end else if (state == IDLE) begin
      diff <= 2'b00;
      s_axis_tready <= ~(s_axis_tvalid & s_axis_tready);
      if (s_axis_tvalid && s_axis_tready) begin
        state <= SYNC;
        sh <= {s_axis_tdata, ~^s_axis_tdata};
        cmd <= s_axis_tuser[7:5] == 3'b100;
        cnt <= cw'(half - 1);
        idx <= '0;
      end
    end else begin
      diff <= lvl ? 2'b10 : 2'b01;
      cnt <= last ? cw'(half - 1) : cnt - 1'b1;
      if (last) begin
        idx <= idx + 1'b1;
        if (state == DATA && idx[0]) sh <= {sh[15:0], 1'b0};
        if (idx == 6'd39) begin
          state <= IDLE;
          s_axis_tready <= 1'b1;
        end else if (idx == 6'd5) state <= DATA;
        else if (idx == 6'd37) state <= PARITY;
      end
    end
  end
endmodule

// File: tb/tb_util_axis_1553_encoder.sv
// tb_util_axis_1553_encoder: scoreboard bench for two encoder instances (HALF=10 and HALF=2).
module tb_util_axis_1553_encoder;
  typedef struct {
    logic [15:0] d;
    logic [7:0]  u;
    int          acc;
  } wrd_t;
  logic clk = 0, arstn = 0;
  logic [15:0] tdata [2];
  logic [7:0]  tuser [2];
  logic        tvalid [2];
  logic        tready [2];
  logic [1:0]  diff [2];
  int cyc = 0, vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference waveform: one level per half-bit derived directly from the word format
  function automatic logic [1:0] exp_at(input logic [15:0] d, input logic [7:0] u, input int h, input int i);
    int hb;
    logic c, b, l;
    hb = i / h;
    c = u[7:5] == 3'b100;
    if (hb < 6) l = (hb < 3) == c;
    else begin
      b = hb < 38 ? d[15 - (hb - 6) / 2] : ($countones(d) % 2 == 0);
      l = (hb % 2) ? !b : b;
    end
    return l ? 2'b10 : 2'b01;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int H = g == 0 ? 10 : 2;
    wrd_t q[$];
    util_axis_1553_encoder #(.clock_speed(g == 0 ? 20000000 : 4000000)) dut (
      .aclk(clk), .arstn(arstn), .s_axis_tdata(tdata[g]), .s_axis_tvalid(tvalid[g]),
      .s_axis_tuser(tuser[g]), .s_axis_tready(tready[g]), .diff(diff[g]));
    always @(posedge clk) if (arstn && tvalid[g] && tready[g]) q.push_back('{tdata[g], tuser[g], cyc});
    initial begin
      wrd_t e;
      int errs, fi;
      logic ab;
      logic [1:0] fd, fe;
      logic ft;
      forever begin
        @(negedge clk);
        if (arstn && diff[g] !== 2'b00) begin
          if (q.size() == 0) chk($sformatf("unexpected_word%0d", g), 32'(diff[g]), 0);
          else begin
            e = q.pop_front();
            chk($sformatf("start_latency%0d", g), cyc, e.acc + 2);
            errs = 0; ab = 0; fi = 0; fd = 0; fe = 0; ft = 0;
            for (int i = 0; i < 40 * H; i++) begin
              if (i > 0) @(negedge clk);
              if (!arstn) begin ab = 1; break; end
              if (diff[g] !== exp_at(e.d, e.u, H, i) || tready[g] !== (i == 40 * H - 1)) begin
                if (errs == 0) begin fi = i; fd = diff[g]; ft = tready[g]; fe = exp_at(e.d, e.u, H, i); end
                errs++;
              end
            end
            if (!ab) begin
              vectors++;
              if (errs != 0) begin
                miscompares++;
                $display("FAIL word%0d d=%h u=%h: %0d bad samples, first at %0d got diff=%b tready=%b expected diff=%b tready=%b",
                         g, e.d, e.u, errs, fi, fd, ft, fe, fi == 40 * H - 1);
              end
              @(negedge clk);
              if (arstn) chk($sformatf("idle_gap%0d", g), 32'(diff[g]), 0);
            end
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [15:0] d, input logic [7:0] usr);
    @(negedge clk);
    tdata[g] = d; tuser[g] = usr; tvalid[g] = 1;
    for (int k = 0; k < 1000 && !tready[g]; k++) @(negedge clk);
    chk("accept", 32'(tready[g]), 1);
    @(posedge clk);
    #1 tvalid[g] = 0;
  endtask

  function automatic logic [7:0] rnd_user();
    return {($urandom % 2) ? 3'b100 : 3'($urandom), 5'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t [3];
    for (int g = 0; g < 2; g++) begin tdata[g] = 0; tuser[g] = 0; tvalid[g] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk($sformatf("reset_state%0d", g), {diff[g], tready[g]}, 0);
    arstn = 1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) chk($sformatf("ready_after_reset%0d", g), 32'(tready[g]), 1);
    send(0, 16'hFFFF, 8'h8F);
    send(1, 16'hA5A5, 8'h8F);
    repeat (410) @(negedge clk);
    send(0, 16'h0000, 8'h40);
    repeat (410) @(negedge clk);
    send(0, 16'h0001, 8'h8F);
    repeat (410) @(negedge clk);
    repeat (6) begin
      send(0, 16'($urandom), rnd_user());
      send(1, 16'($urandom), rnd_user());
      repeat ($urandom_range(0, 450)) @(negedge clk);
    end
    repeat (410) @(negedge clk);
    tdata[0] = 16'hFFFF; tuser[0] = 8'h8F; tvalid[0] = 1;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 1000 && !tready[0]; k++) @(negedge clk);
      chk("stream_accept", 32'(tready[0]), 1);
      @(posedge clk);
      #1 t[n] = cyc;
      tdata[0] = tdata[0] + 1'b1;
      if (n == 2) tvalid[0] = 0;
      else @(negedge clk);
    end
    chk("stream_period1", t[1] - t[0], 401);
    chk("stream_period2", t[2] - t[1], 401);
    repeat (410) @(negedge clk);
    send(0, 16'($urandom), 8'h8F);
    repeat (100) @(negedge clk);
    #2 arstn = 0;
    #1 chk("async_reset_mid_word", {diff[0], tready[0]}, 0);
    repeat (2) @(negedge clk);
    arstn = 1;
    @(posedge clk);
    #1 chk("ready_after_mid_reset", 32'(tready[0]), 1);
    repeat (50) @(negedge clk);
    chk("no_resume", 32'(diff[0]), 0);
    send(0, 16'($urandom), rnd_user());
    repeat (410) @(negedge clk);
    chk("queue0_drained", u[0].q.size(), 0);
    chk("queue1_drained", u[1].q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
